mem_bus_arbiter: RTL

- Shares the single external 16-bit SRAM between the instruction-fetch port (IF) and the data-access port (MEM).
- Sequences the SRAM control strobes (en_n/oe_n/we_n) for multi-cycle reads and writes.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Sits between the pipeline (after the MemDataMux write-data selection) and the board SRAM pins.

---
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the pipeline-side request/response signals and the SRAM pin signals
// shared by the memory bus arbiter. The slave modport is the arbiter's view;
// the master modport is the pipeline plus SRAM side.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   // instruction-fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   // data-access port
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   // pipeline status
   logic              stall_if;
   logic              stall_mem;
   logic              proto_err;
   // SRAM pins
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dq_o;
   logic              ram_dq_oe;
   logic [DATA_W-1:0] ram_dq_i;
   logic              ram_en_n;
   logic              ram_oe_n;
   logic              ram_we_n;

   modport slave (
      input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_dq_i,
      output if_rdata, if_ready, mem_rdata, mem_ready,
      output stall_if, stall_mem, proto_err,
      output ram_addr, ram_dq_o, ram_dq_oe, ram_en_n, ram_oe_n, ram_we_n
   );

   modport master (
      output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_dq_i,
      input  if_rdata, if_ready, mem_rdata, mem_ready,
      input  stall_if, stall_mem, proto_err,
      input  ram_addr, ram_dq_o, ram_dq_oe, ram_en_n, ram_oe_n, ram_we_n
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one external SRAM between the instruction-fetch port and the data
// port. MEM has fixed priority over IF. Reads take one strobe cycle, writes
// run SETUP / WE_CYCLES pulse cycles / HOLD, and every access ends with a
// one-cycle DONE state that drives the owner's ready pulse.
module mem_bus_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int WE_CYCLES = 1    // legal range 1..4
) (
   input  logic                clk,
   input  logic                rst,  // asynchronous, active low
   mem_bus_arbiter_if.slave    bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_DONE
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_MEM
   } owner_t;

   state_t            state_q,     state_d;
   owner_t            owner_q,     owner_d;
   logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              proto_err_q, proto_err_d;
   logic [1:0]        we_cnt_q,    we_cnt_d;

   // State and datapath registers; reset returns the FSM to IDLE at once so
   // the strobes decoded from it go inactive even in the middle of a write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_IF;
         ram_addr_q  <= '0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         proto_err_q <= 1'b0;
         we_cnt_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values; blocking would make results order dependent.
         state_q     <= state_d;
         owner_q     <= owner_d;
         ram_addr_q  <= ram_addr_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         proto_err_q <= proto_err_d;
         we_cnt_q    <= we_cnt_d;
      end
   end

   // Next-state logic: arbitration in IDLE, read capture, write-pulse count.
   always_comb begin
      // NOTE: every target gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d     = state_q;
      owner_d     = owner_q;
      ram_addr_d  = ram_addr_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      proto_err_d = 1'b0;
      we_cnt_d    = we_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.mem_wr) begin
               // a write wins over a simultaneous read, which is flagged
               state_d     = S_WR_SETUP;
               owner_d     = OWN_MEM;
               ram_addr_d  = bus.mem_addr;
               wdata_d     = bus.mem_wdata;
               proto_err_d = bus.mem_rd;
            end else if (bus.mem_rd) begin
               state_d    = S_READ;
               owner_d    = OWN_MEM;
               ram_addr_d = bus.mem_addr;
            end else if (bus.if_req) begin
               state_d    = S_READ;
               owner_d    = OWN_IF;
               ram_addr_d = bus.if_addr;
            end
         end
         S_READ: begin
            if (owner_q == OWN_MEM) mem_rdata_d = bus.ram_dq_i;
            else                    if_rdata_d  = bus.ram_dq_i;
            state_d = S_DONE;
         end
         S_WR_SETUP: begin
            we_cnt_d = 2'(WE_CYCLES - 1);
            state_d  = S_WR_PULSE;
         end
         S_WR_PULSE: begin
            if (we_cnt_q == '0) state_d  = S_WR_HOLD;
            else                we_cnt_d = we_cnt_q - 2'd1;
         end
         S_WR_HOLD: state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;  // requests deliberately not sampled
         default:   state_d = S_IDLE;
      endcase
   end

   // SRAM strobe and ready decode, purely from the registered state so we_n
   // and oe_n can never be low together.
   always_comb begin
      bus.ram_en_n  = 1'b1;
      bus.ram_oe_n  = 1'b1;
      bus.ram_we_n  = 1'b1;
      bus.ram_dq_oe = 1'b0;
      bus.if_ready  = 1'b0;
      bus.mem_ready = 1'b0;
      unique case (state_q)
         S_READ: begin
            bus.ram_en_n = 1'b0;
            bus.ram_oe_n = 1'b0;
         end
         S_WR_SETUP, S_WR_HOLD: begin
            bus.ram_en_n  = 1'b0;
            bus.ram_dq_oe = 1'b1;
         end
         S_WR_PULSE: begin
            bus.ram_en_n  = 1'b0;
            bus.ram_we_n  = 1'b0;
            bus.ram_dq_oe = 1'b1;
         end
         S_DONE: begin
            bus.if_ready  = (owner_q == OWN_IF);
            bus.mem_ready = (owner_q == OWN_MEM);
         end
         default: ;
      endcase
   end

   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_dq_o  = wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.mem_rdata = mem_rdata_q;
   assign bus.proto_err = proto_err_q;
   assign bus.stall_if  = bus.if_req & ~bus.if_ready;
   assign bus.stall_mem = (bus.mem_rd | bus.mem_wr) & ~bus.mem_ready;

endmodule
